mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified, variable-latency memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between the fetch/memory stages and the memory model. Latches one transaction at a time and runs the memory req/ack handshake.
- Returns read data and a one-cycle done pulse to the requester it served.
- Fixed D-over-I priority, with a starvation bound so fetch always makes progress.

Parameters:
- DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- ADDR_WIDTH, 32, address width.
- STARVE_LIMIT, 4, maximum consecutive D grants while I is waiting; range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- i_req  input  1  fetch request; held until i_done.
- i_addr  input  ADDR_WIDTH  fetch address; stable while i_req is high.
- i_rdata  output  DATA_WIDTH  fetched word; valid when i_done is high, holds value otherwise.
- i_done  output  1  one-cycle completion pulse for I.
- d_req  input  1  load/store request; held until d_done.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_WIDTH  load/store address.
- d_wdata  input  DATA_WIDTH  store data.
- d_be  input  DATA_WIDTH/8  store byte enables.
- d_rdata  output  DATA_WIDTH  load data; valid when d_done is high.
- d_done  output  1  one-cycle completion pulse for D.
- mem_req  output  1  memory request, held until mem_ack.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_be  output  DATA_WIDTH/8  memory byte enables.
- mem_ack  input  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  input  DATA_WIDTH  memory read data.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0, including i_rdata, d_rdata, mem_* and busy; starve counter=0. Takes effect immediately.
- Reset mid-transaction: mem_req drops in the same cycle and the transaction is abandoned. No done pulse is issued.
- States: IDLE, SERVE_I, SERVE_D, RESP.
- IDLE, grant decision on each clock edge:
  - if d_req && !(i_req && cnt==STARVE_LIMIT) -> SERVE_D;
  - else if i_req -> SERVE_I;
  - else stay in IDLE.
- At grant: register address, we, wdata and be into mem_* outputs.
  - For I grants, mem_we=0 and mem_be=all ones.
- Starve counter:
  - D grant with i_req high -> cnt+1, saturating at STARVE_LIMIT.
  - D grant with i_req low -> cnt=0.
  - Any I grant -> cnt=0.
- SERVE_x: mem_req=1 and mem_* held constant.
  - On mem_ack=1: capture mem_rdata into x_rdata, drop mem_req at the edge, and go to RESP.
  - Loads and fetches capture mem_rdata.
  - Stores also capture mem_rdata; the value is don't-care for the requester.
- RESP: x_done=1 for exactly one cycle for the served port only; next state is IDLE.
  - No grant is made in RESP; the requester must drop or refresh its req here.
  - A req still high in the next IDLE cycle is a new transaction.
- Latency: req high at edge N (state IDLE) -> mem_req high from N+1.
  - With mem_ack at edge M (M ≥ N+1), x_done is high in cycle M+1.
  - Minimum request-to-done is 3 cycles; back-to-back throughput is one transaction per 3 cycles at zero wait.
- mem_ack in IDLE or RESP is ignored. Input changes on a port while it is being served are ignored, because values were latched at grant.
- Simultaneous i_req and d_req in IDLE resolve per the rule above. Never grant both; mem_req never carries mixed I/D fields.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately, state IDLE, busy=0. Release, then i_req with addr 0x0 -> mem_req high one cycle later with mem_addr=0x0, mem_we=0.
- Single fetch: i_addr=0x10, memory acks after 2 wait cycles with 0x00500093 -> i_done pulses 1 cycle with i_rdata=0x00500093; d_done stays 0.
- Store: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1 and those fields held stable until ack; d_done one pulse.
- Contention: i_req and d_req rise together (load 0x200, fetch 0x4) -> D served first. I is granted in the IDLE after D's RESP; 2 done pulses, D then I.
- Starvation (STARVE_LIMIT=4): d_req held continuously with i_req high -> exactly 4 D transactions, then the I transaction, then D resumes; cnt back to 0.
- Zero-wait memory: mem_ack tied high -> each transaction completes in exactly 3 cycles. Asserting rst while in SERVE_D -> mem_req falls immediately, no d_done.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch (I) and load/store (D).
// D wins ties unless I has waited through STARVE_LIMIT consecutive D grants.
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_done,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_done,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       served_d;
    logic       grant_i, grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(i_req && cnt == LIMIT)) begin
                    grant_d   = 1'b1;
                    state_nxt = SERVE_D;
                end else if (i_req) begin
                    grant_i   = 1'b1;
                    state_nxt = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: if (mem_ack) state_nxt = RESP;
            RESP:             state_nxt = IDLE;
            default:          state_nxt = IDLE;
        endcase
    end

    // Handshake and done outputs decode straight from state so reset clears them at once.
    assign mem_req = (state == SERVE_I) || (state == SERVE_D);
    assign busy    = (state != IDLE);
    assign i_done  = (state == RESP) && !served_d;
    assign d_done  = (state == RESP) && served_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            served_d  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant_d) begin
                served_d  <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
                if (!i_req)          cnt <= '0;
                else if (cnt < LIMIT) cnt <= cnt + 4'd1;
            end else if (grant_i) begin
                served_d  <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
                mem_wdata <= '0;
                mem_be    <= {BE_W{1'b1}};
                cnt       <= '0;
            end
            // Stores capture too; the requester ignores d_rdata in that case.
            if (state == SERVE_D && mem_ack) d_rdata <= mem_rdata;
            if (state == SERVE_I && mem_ack) i_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: queued requesters, a wait-state memory model,
// and per-scenario tasks checking order, data, timing and reset behaviour.
module tb_mem_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [BW-1:0] d_be = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BW-1:0] be; } txn_t;
    typedef struct { logic d; logic chk; logic [DW-1:0] data; } exp_t;

    txn_t ipend[$];
    txn_t dpend[$];
    exp_t expq[$];
    int   done_cyc[$];
    int   nchecks = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   mem_wait = 0;
    int   wcnt = 0;
    bit   tie_ack = 1'b0;
    logic prev_done = 1'b0;

    function automatic logic [DW-1:0] rdata_fn(input logic [AW-1:0] a);
        return (a == 32'h10) ? 32'h0050_0093 : ((a ^ 32'h5A5A_0000) + 32'h11);
    endfunction

    function automatic void push_i(input logic [AW-1:0] a);
        txn_t t;
        t.we = 1'b0; t.addr = a; t.wdata = '0; t.be = '1;
        ipend.push_back(t);
    endfunction

    function automatic void push_d(input logic we, input logic [AW-1:0] a,
                                   input logic [DW-1:0] wd, input logic [BW-1:0] be);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = wd; t.be = be;
        dpend.push_back(t);
    endfunction

    function automatic void push_exp(input logic d, input logic chk, input logic [DW-1:0] data);
        exp_t e;
        e.d = d; e.chk = chk; e.data = data;
        expq.push_back(e);
    endfunction

    always @(posedge clk) cyc++;

    // Memory model: acks after mem_wait idle cycles of mem_req, or constantly when tie_ack.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0; wcnt = 0;
        end else if (tie_ack) begin
            mem_ack = 1'b1; mem_rdata = rdata_fn(mem_addr);
        end else if (mem_req && !mem_ack) begin
            if (wcnt >= mem_wait) begin
                mem_ack = 1'b1; mem_rdata = rdata_fn(mem_addr); wcnt = 0;
            end else wcnt++;
        end else mem_ack = 1'b0;
    end

    // Requesters hold req until done and refresh it in RESP from their pending queue; scoreboard pops on done.
    always @(negedge clk) begin
        if (rst) begin
            i_req = 1'b0; d_req = 1'b0; prev_done = 1'b0;
        end else begin
            if (i_done || d_done) begin
                exp_t e;
                nchecks++;
                if (i_done && d_done) begin
                    nfail++; $display("FAIL both_done at cycle %0d: i_done=1 d_done=1, required only one", cyc);
                end else if (prev_done) begin
                    nfail++; $display("FAIL done_width at cycle %0d: done high two cycles, required one-cycle pulse", cyc);
                end else if (expq.size() == 0) begin
                    nfail++; $display("FAIL unexpected_done at cycle %0d: i_done=%0b d_done=%0b, required none", cyc, i_done, d_done);
                end else begin
                    e = expq.pop_front();
                    if (d_done !== e.d) begin
                        nfail++; $display("FAIL done_port at cycle %0d: d_done=%0b, required d=%0b", cyc, d_done, e.d);
                    end else if (e.chk && ((e.d ? d_rdata : i_rdata) !== e.data)) begin
                        nfail++; $display("FAIL rdata at cycle %0d: got %08h, required %08h", cyc, (e.d ? d_rdata : i_rdata), e.data);
                    end
                end
                done_cyc.push_back(cyc);
            end
            prev_done = i_done || d_done;
            if (i_done && ipend.size() > 0) ipend.delete(0);
            if (d_done && dpend.size() > 0) dpend.delete(0);
            if (ipend.size() > 0) begin i_req = 1'b1; i_addr = ipend[0].addr; end
            else i_req = 1'b0;
            if (dpend.size() > 0) begin
                d_req = 1'b1; d_we = dpend[0].we; d_addr = dpend[0].addr;
                d_wdata = dpend[0].wdata; d_be = dpend[0].be;
            end else d_req = 1'b0;
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        tie_ack = 1'b0;
        ipend.delete(); dpend.delete(); expq.delete(); done_cyc.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while ((expq.size() != 0 || ipend.size() != 0 || dpend.size() != 0) && n < max) begin
            @(posedge clk); n++;
        end
        nchecks++;
        if (expq.size() != 0 || ipend.size() != 0 || dpend.size() != 0) begin
            nfail++; $display("FAIL %s_timeout: %0d done pulses outstanding, required 0", name, expq.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_req(input string name);
        int n = 0;
        while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
        nchecks++;
        if (!mem_req) begin nfail++; $display("FAIL %s_no_mem_req: mem_req=0, required 1", name); end
    endtask

    task automatic test_reset();
        mem_wait = 0;
        push_i(32'h0); push_exp(1'b0, 1'b1, rdata_fn(32'h0));
        @(negedge clk); #1;
        nchecks++;
        if (mem_req !== 1'b0) begin nfail++; $display("FAIL reset_pre_grant: mem_req=%0b, required 0", mem_req); end
        @(posedge clk); #1;
        nchecks++;
        if ({mem_req, mem_we, mem_addr, mem_be, busy} !== {1'b1, 1'b0, 32'h0, 4'hF, 1'b1}) begin
            nfail++; $display("FAIL reset_first_grant: req=%0b we=%0b addr=%08h be=%h busy=%0b, required 1 0 00000000 f 1",
                              mem_req, mem_we, mem_addr, mem_be, busy);
        end
        wait_drain("reset_fetch", 20);
        mem_wait = 4;
        push_d(1'b1, 32'h44, 32'h1234_5678, 4'hC);
        wait_mem_req("reset_mid");
        #2 rst = 1'b1;
        #1;
        nchecks++;
        if ({i_rdata, i_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy} !== '0) begin
            nfail++; $display("FAIL reset_outputs: req=%0b we=%0b addr=%08h wdata=%08h be=%h busy=%0b i_rdata=%08h d_rdata=%08h, required all 0",
                              mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, i_rdata, d_rdata);
        end
        apply_reset();
    endtask

    task automatic test_single_fetch();
        mem_wait = 2;
        push_i(32'h10); push_exp(1'b0, 1'b1, 32'h0050_0093);
        wait_drain("single_fetch", 30);
    endtask

    task automatic test_store();
        int n = 0;
        mem_wait = 3;
        push_d(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011); push_exp(1'b1, 1'b0, '0);
        wait_mem_req("store");
        while (mem_req && n < 20) begin
            nchecks++;
            if ({mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011}) begin
                nfail++; $display("FAIL store_fields: we=%0b addr=%08h wdata=%08h be=%b, required 1 00000100 deadbeef 0011",
                                  mem_we, mem_addr, mem_wdata, mem_be);
            end
            @(posedge clk); #1; n++;
        end
        wait_drain("store", 30);
    endtask

    task automatic test_contention();
        mem_wait = 1;
        push_i(32'h4);
        push_d(1'b0, 32'h200, '0, 4'hF);
        push_exp(1'b1, 1'b1, rdata_fn(32'h200));
        push_exp(1'b0, 1'b1, rdata_fn(32'h4));
        wait_drain("contention", 40);
    endtask

    task automatic test_starvation();
        apply_reset();
        mem_wait = 0;
        push_i(32'h8);
        for (int k = 0; k < 6; k++) push_d(1'b0, 32'h300 + 32'(4 * k), '0, 4'hF);
        for (int k = 0; k < 4; k++) push_exp(1'b1, 1'b1, rdata_fn(32'h300 + 32'(4 * k)));
        push_exp(1'b0, 1'b1, rdata_fn(32'h8));
        for (int k = 4; k < 6; k++) push_exp(1'b1, 1'b1, rdata_fn(32'h300 + 32'(4 * k)));
        wait_drain("starvation", 80);
        nchecks++;
        if (dut.cnt !== 4'd0) begin nfail++; $display("FAIL starve_cnt: cnt=%0d, required 0", dut.cnt); end
    endtask

    task automatic test_back_to_back();
        int p;
        done_cyc.delete();
        tie_ack = 1'b1;
        p = cyc;
        for (int k = 0; k < 3; k++) begin
            push_d(1'b0, 32'h500 + 32'(4 * k), '0, 4'hF);
            push_exp(1'b1, 1'b1, rdata_fn(32'h500 + 32'(4 * k)));
        end
        wait_drain("back_to_back", 30);
        tie_ack = 1'b0;
        nchecks++;
        if (done_cyc.size() != 3) begin
            nfail++; $display("FAIL b2b_count: %0d done pulses, required 3", done_cyc.size());
        end else begin
            if (done_cyc[0] != p + 2) begin
                nfail++; $display("FAIL b2b_latency: first done at cycle %0d, required %0d", done_cyc[0], p + 2);
            end
            nchecks++;
            if (done_cyc[1] - done_cyc[0] != 3 || done_cyc[2] - done_cyc[1] != 3) begin
                nfail++; $display("FAIL b2b_spacing: gaps %0d %0d, required 3 3",
                                  done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
            end
        end
    endtask

    task automatic test_reset_in_serve_d();
        mem_wait = 5;
        push_d(1'b0, 32'h400, '0, 4'hF);
        wait_mem_req("rst_serve_d");
        #2 rst = 1'b1;
        #1;
        nchecks++;
        if ({mem_req, busy, d_done} !== 3'b000) begin
            nfail++; $display("FAIL rst_serve_d: mem_req=%0b busy=%0b d_done=%0b, required 0 0 0", mem_req, busy, d_done);
        end
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            nchecks++;
            if (d_done !== 1'b0 || mem_req !== 1'b0) begin
                nfail++; $display("FAIL rst_abandon: d_done=%0b mem_req=%0b, required 0 0", d_done, mem_req);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_single_fetch();
        test_store();
        test_contention();
        test_starvation();
        test_back_to_back();
        test_reset_in_serve_d();
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end
endmodule
